reg_write_arbiter: RTL and testbench

Round-robin write arbiter that shares one 7-bit enable-gated storage register between N requesters. A four-state FSM sequences each access: grant, one-cycle write enable, acknowledge, and release. It sits between several producer blocks and the single holding register they update. Its output is the registered value that downstream logic reads.

---
 rtl/reg_arb_pkg.sv | 14 +
 rtl/shared_reg.sv | 24 ++
 rtl/reg_write_arbiter.sv | 127 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register write arbiter: FSM state encoding
// and the default data width of the shared holding register.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam int DW_DEFAULT = 7;

endpackage

// File: rtl/shared_reg.sv
// Enable-gated holding register shared by all requesters.
// Loads d when en is high, otherwise keeps its own value.
module shared_reg
    import reg_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    // Storage: async clear, load on enable, recirculate otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of a single shared register.
// Each access walks IDLE -> WRITE -> ACK -> RELEASE.
// Optional feature: define REG_ARB_WCOUNT_EN to add the wr_cnt
// completed-write counter port.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] wdata,
    output logic [N-1:0]    gnt,
    output logic            ack,
    output logic            busy,
    output logic [DW-1:0]   q
`ifdef REG_ARB_WCOUNT_EN
    ,
    output logic [7:0]      wr_cnt
`endif
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    arb_state_t     state;
    arb_state_t     state_next;
    logic [N-1:0]   gnt_next;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  ptr_next;
    logic [IW-1:0]  winner;
    logic [IW-1:0]  winner_next;
    logic [IW-1:0]  search_idx;
    logic           search_found;
    logic           reg_en;
    logic [DW-1:0]  reg_d;

    // Find the first active request starting at ptr and wrapping round.
    always_comb begin
        search_found = 1'b0;
        search_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!search_found && req[(int'(ptr) + i) % N]) begin
                search_found = 1'b1;
                search_idx   = IW'((int'(ptr) + i) % N);
            end
        end
    end

    // Next-state, next-grant and pointer advance for the access sequence.
    always_comb begin
        state_next  = state;
        gnt_next    = gnt;
        ptr_next    = ptr;
        winner_next = winner;
        case (state)
            IDLE: begin
                gnt_next = '0;
                if (search_found) begin
                    gnt_next[search_idx] = 1'b1;
                    winner_next          = search_idx;
                    state_next           = WRITE;
                end
            end
            WRITE: begin
                ptr_next   = IW'((int'(winner) + 1) % N);
                state_next = ACK;
            end
            ACK: begin
                state_next = RELEASE;
            end
            RELEASE: begin
                if (!req[winner]) begin
                    gnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                gnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // FSM state, grant, round-robin pointer and captured winner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= '0;
            ptr    <= '0;
            winner <= '0;
        end else begin
            state  <= state_next;
            gnt    <= gnt_next;
            ptr    <= ptr_next;
            winner <= winner_next;
        end
    end

    assign ack    = (state == ACK);
    assign busy   = (state != IDLE);
    assign reg_en = (state == WRITE);
    assign reg_d  = wdata[int'(winner) * DW +: DW];

    shared_reg #(
        .DW (DW)
    ) u_shared_reg (
        .clk   (clk),
        .reset (reset),
        .en    (reg_en),
        .d     (reg_d),
        .q     (q)
    );

`ifdef REG_ARB_WCOUNT_EN
    // Count every write as the FSM leaves WRITE; wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt <= '0;
        end else if (state == WRITE) begin
            wr_cnt <= wr_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter (N = 4, DW = 7).
// Expected writes are queued when stimulus is driven and checked on each ack.
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 7;

    typedef struct {
        int          idx;
        logic [6:0]  data;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt;
    logic            ack;
    logic            busy;
    logic [DW-1:0]   q;
`ifdef REG_ARB_WCOUNT_EN
    logic [7:0]      wr_cnt;
`endif

    int   checks;
    int   failures;
    exp_t sb[$];

    reg_write_arbiter #(
        .N  (N),
        .DW (DW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wdata  (wdata),
        .gnt    (gnt),
        .ack    (ack),
        .busy   (busy),
        .q      (q)
`ifdef REG_ARB_WCOUNT_EN
        ,
        .wr_cnt (wr_cnt)
`endif
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic pushExp(input int idx, input logic [6:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic setData(input logic [6:0] d0, input logic [6:0] d1,
                           input logic [6:0] d2, input logic [6:0] d3);
        wdata = {d3, d2, d1, d0};
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            nextCycle();
            n++;
        end
        if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Drive req and let each winner drop its request in its ACK cycle,
    // optionally re-raising it two cycles later; stop after 'grants' acks.
    task automatic applyStimulus(input logic [N-1:0] startReq, input int grants,
                                 input bit reraise);
        int cnt[N];
        int done;
        int cycles;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        done   = 0;
        cycles = 0;
        req    = startReq;
        while (done < grants && cycles < 200) begin
            nextCycle();
            cycles++;
            for (int i = 0; i < N; i++) begin
                if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) req[i] = 1'b1;
                end
            end
            if (ack) begin
                for (int i = 0; i < N; i++) begin
                    if (gnt[i]) begin
                        req[i] = 1'b0;
                        if (reraise) cnt[i] = 2;
                    end
                end
                done++;
                if (done == grants) req = '0;
            end
        end
        if (done < grants) checkOutput("grant_timeout", 32'(done), 32'(grants));
        req = '0;
        waitIdle();
    endtask

    // Scoreboard: every ack must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && ack) begin
            if (sb.size() == 0) begin
                checkOutput("ack_unexpected", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_gnt", 32'(gnt), 32'(4'b0001 << e.idx));
                checkOutput("sb_q", 32'(q), 32'(e.data));
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        req      = '0;
        wdata    = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_q", 32'(q), 32'd0);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
`ifdef REG_ARB_WCOUNT_EN
        checkOutput("rst_wr_cnt", 32'(wr_cnt), 32'd0);
`endif
        reset = 1'b0;
        nextCycle();

        // Single write from requester 0
        setData(7'h2A, 7'h00, 7'h00, 7'h00);
        req = 4'b0001;
        pushExp(0, 7'h2A);
        @(negedge clk);
        checkOutput("single_gnt_T", 32'(gnt), 32'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("single_gnt_T1", 32'(gnt), 32'b0001);
        checkOutput("single_busy_T1", 32'(busy), 32'd1);
        nextCycle();
        req = '0;
        @(negedge clk);
        checkOutput("single_ack_T2", 32'(ack), 32'd1);
        checkOutput("single_q_T2", 32'(q), 32'h2A);
        nextCycle();
        @(negedge clk);
        checkOutput("single_ack_T3", 32'(ack), 32'd0);
        checkOutput("single_gnt_T3", 32'(gnt), 32'b0001);
        nextCycle();
        @(negedge clk);
        checkOutput("single_gnt_T4", 32'(gnt), 32'd0);
        checkOutput("single_busy_T4", 32'(busy), 32'd0);
        nextCycle();

        // Reset asserted in the middle of WRITE
        setData(7'h55, 7'h00, 7'h00, 7'h00);
        req = 4'b0001;
        nextCycle();
        reset = 1'b1;
        req   = '0;
        #1;
        checkOutput("midrst_q", 32'(q), 32'd0);
        checkOutput("midrst_gnt", 32'(gnt), 32'd0);
        checkOutput("midrst_ack", 32'(ack), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nextCycle();
        @(negedge clk);
        checkOutput("midrst_idle_busy", 32'(busy), 32'd0);
        checkOutput("midrst_idle_q", 32'(q), 32'd0);
        nextCycle();

        // Round robin with every requester re-requesting, ptr starts at 0
        setData(7'h31, 7'h42, 7'h53, 7'h64);
        pushExp(0, 7'h31);
        pushExp(1, 7'h42);
        pushExp(2, 7'h53);
        pushExp(3, 7'h64);
        pushExp(0, 7'h31);
        applyStimulus(4'b1111, 5, 1'b1);

        // Move ptr to 2 with a write from requester 1, then req = 1011
        setData(7'h0A, 7'h1B, 7'h2C, 7'h3D);
        pushExp(1, 7'h1B);
        applyStimulus(4'b0010, 1, 1'b0);
        pushExp(3, 7'h3D);
        pushExp(0, 7'h0A);
        pushExp(1, 7'h1B);
        applyStimulus(4'b1011, 3, 1'b0);

        // Hold stability after a write of 7'h11 (ptr is now 2)
        setData(7'h00, 7'h00, 7'h11, 7'h00);
        pushExp(2, 7'h11);
        applyStimulus(4'b0100, 1, 1'b0);
        setData(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("hold_q", 32'(q), 32'h11);
            checkOutput("hold_busy", 32'(busy), 32'd0);
        end
        nextCycle();

`ifdef REG_ARB_WCOUNT_EN
        // 257 writes wrap the counter to 1
        reset = 1'b1;
        #2;
        reset = 1'b0;
        nextCycle();
        for (int k = 0; k < 257; k++) begin
            setData(7'(k), 7'h00, 7'h00, 7'h00);
            pushExp(0, 7'(k));
            applyStimulus(4'b0001, 1, 1'b0);
        end
        @(negedge clk);
        checkOutput("wr_cnt_257", 32'(wr_cnt), 32'd1);
`endif

        repeat (3) nextCycle();
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
